// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: main-control operation classes,
// 4-bit ALU control codes and branch funct3 values.
package alu_pkg;

    // Operation class from main control; 101-111 are unused and decode to ADD.
    localparam logic [2:0] LDST   = 3'b000;
    localparam logic [2:0] BRANCH = 3'b001;
    localparam logic [2:0] RTYPE  = 3'b010;
    localparam logic [2:0] ITYPE  = 3'b011;
    localparam logic [2:0] LUI    = 3'b100;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_SLL   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_ctrl_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-control decoder: maps the main-control class code plus
// funct3/funct7[5] onto the 4-bit ALU operation.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_ctrl_e  alu_ctrl
);

    always_comb begin
        // NOTE: default assigned first so every path drives alu_ctrl and no latch is inferred.
        alu_ctrl = ALU_ADD;
        case (alu_op)
            LDST: alu_ctrl = ALU_ADD;
            BRANCH: begin
                case (funct3)
                    F3_BEQ, F3_BNE:   alu_ctrl = ALU_SUB;
                    F3_BLT, F3_BGE:   alu_ctrl = ALU_SLT;
                    F3_BLTU, F3_BGEU: alu_ctrl = ALU_SLTU;
                    default:          alu_ctrl = ALU_SUB;
                endcase
            end
            RTYPE, ITYPE: begin
                case (funct3)
                    // Immediate adds reuse bit 30 as an immediate bit, so it only selects SUB for R-type.
                    3'b000:  alu_ctrl = (alu_op == RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            LUI:     alu_ctrl = ALU_PASSB;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered RISC-V execute stage: ALU-control decode, 32-bit ALU, PC+4 and
// PC+imm adders. Define ALU_OVERFLOW_EN to add the signed-overflow output.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [2:0]      alu_op,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            branch_taken,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] branch_target
`ifdef ALU_OVERFLOW_EN
    ,
    output logic            overflow
`endif
);

    alu_ctrl_e       alu_ctrl;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            taken;
    logic [4:0]      shamt;

    alu_ctrl_dec u_ctrl_dec (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (alu_ctrl)
    );

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_AND:   alu_result = op_a & op_b;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_ADD:   alu_result = sum;
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SLL:   alu_result = op_a << shamt;
            ALU_SRL:   alu_result = op_a >> shamt;
            ALU_SUB:   alu_result = diff;
            ALU_SRA:   alu_result = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == '0);

    always_comb begin
        taken = 1'b0;
        if (alu_op == BRANCH) begin
            case (funct3)
                F3_BEQ:           taken = alu_zero;
                F3_BNE:           taken = !alu_zero;
                F3_BLT, F3_BLTU:  taken = alu_result[0];
                F3_BGE, F3_BGEU:  taken = !alu_result[0];
                default:          taken = 1'b0;
            endcase
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf;

    // Signed overflow: ADD with like-signed operands, SUB with unlike-signed, and the result sign flips away from op_a.
    always_comb begin
        ovf = 1'b0;
        case (alu_ctrl)
            ALU_ADD: ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
            ALU_SUB: ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments in clocked logic so every register samples pre-edge values.
            out_valid     <= 1'b0;
            result        <= '0;
            zero          <= 1'b0;
            branch_taken  <= 1'b0;
            pc_plus4      <= '0;
            branch_target <= '0;
`ifdef ALU_OVERFLOW_EN
            overflow      <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            // Data outputs hold their last values across idle cycles.
            if (in_valid) begin
                result        <= alu_result;
                zero          <= alu_zero;
                branch_taken  <= taken;
                pc_plus4      <= pc + XLEN'(4);
                branch_target <= pc + imm;
`ifdef ALU_OVERFLOW_EN
                overflow      <= ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; honours ALU_OVERFLOW_EN.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [2:0]  alu_op;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .op_a          (op_a),
        .op_b          (op_b),
        .pc            (pc),
        .imm           (imm),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .alu_op        (alu_op),
        .out_valid     (out_valid),
        .result        (result),
        .zero          (zero),
        .branch_taken  (branch_taken),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow      (overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one operation at the falling edge, then settle just after the next rising edge.
    task automatic step(input logic v, input logic [2:0] aop, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i);
        @(negedge clk);
        in_valid = v; alu_op = aop; funct3 = f3; funct7_5 = f7;
        op_a = a; op_b = b; pc = p; imm = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b1; alu_op = 3'b010; funct3 = 3'b000; funct7_5 = 1'b0;
        op_a = 32'h11; op_b = 32'h22; pc = 32'h100; imm = 32'h40;

        // Reset held two edges with in_valid asserted.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h0);
        check("rst_branch_taken", {31'b0, branch_taken}, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h0);
        check("rst_branch_target", branch_target, 32'h0);
`ifdef ALU_OVERFLOW_EN
        check("rst_overflow", {31'b0, overflow}, 32'h0);
`endif

        // First valid after release: R-type SUB 5-7, visible only after the next edge.
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1; alu_op = 3'b010; funct3 = 3'b000; funct7_5 = 1'b1;
        op_a = 32'd5; op_b = 32'd7; pc = 32'h1000; imm = 32'h20;
        #1;
        check("lat_before_edge", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("sub_valid", {31'b0, out_valid}, 32'h1);
        check("sub_result", result, 32'hFFFF_FFFE);
        check("sub_zero", {31'b0, zero}, 32'h0);
        check("sub_pc_plus4", pc_plus4, 32'h0000_1004);
        check("sub_target", branch_target, 32'h0000_1020);

        step(1'b1, 3'b010, 3'b000, 1'b1, 32'd7, 32'd7, 32'h0, 32'h0);
        check("sub_eq_result", result, 32'h0);
        check("sub_eq_zero", {31'b0, zero}, 32'h1);

        step(1'b1, 3'b011, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
        check("srai_result", result, 32'hF800_0000);
        step(1'b1, 3'b011, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
        check("srli_result", result, 32'h0800_0000);

        // ADDI whose immediate has bit 30 set must still add.
        step(1'b1, 3'b011, 3'b000, 1'b1, 32'd5, 32'd7, 32'h0, 32'h0);
        check("addi_f7_result", result, 32'd12);

        step(1'b1, 3'b001, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("blt_taken", {31'b0, branch_taken}, 32'h1);
        step(1'b1, 3'b001, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("bltu_taken", {31'b0, branch_taken}, 32'h0);
        step(1'b1, 3'b001, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("bge_taken", {31'b0, branch_taken}, 32'h0);
        step(1'b1, 3'b001, 3'b000, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0);
        check("beq_taken", {31'b0, branch_taken}, 32'h1);
        step(1'b1, 3'b001, 3'b001, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0);
        check("bne_taken", {31'b0, branch_taken}, 32'h0);
        step(1'b1, 3'b001, 3'b010, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0);
        check("br_f3_010_taken", {31'b0, branch_taken}, 32'h0);

        // Non-branch op with a zero result must not report a taken branch.
        step(1'b1, 3'b010, 3'b000, 1'b1, 32'd9, 32'd9, 32'h0, 32'h0);
        check("rtype_no_branch", {31'b0, branch_taken}, 32'h0);

        step(1'b1, 3'b000, 3'b010, 1'b0, 32'h10, 32'h4, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
        check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        check("wrap_target", branch_target, 32'hFFFF_FFF4);
        check("ldst_result", result, 32'h14);

        // Idle cycle: out_valid drops, data holds.
        step(1'b0, 3'b010, 3'b100, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h200, 32'h8);
        check("idle_valid", {31'b0, out_valid}, 32'h0);
        check("idle_hold_result", result, 32'h14);
        check("idle_hold_pc_plus4", pc_plus4, 32'h0000_0000);

        step(1'b1, 3'b100, 3'b000, 1'b1, 32'hDEAD_BEEF, 32'h1234_5000, 32'h0, 32'h0);
        check("lui_result", result, 32'h1234_5000);
        check("lui_valid", {31'b0, out_valid}, 32'h1);
        step(1'b1, 3'b010, 3'b001, 1'b0, 32'd1, 32'h21, 32'h0, 32'h0);
        check("sll_shamt_result", result, 32'd2);
        step(1'b1, 3'b010, 3'b100, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0);
        check("xor_result", result, 32'h0000_0FF0);
        step(1'b1, 3'b011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'h0);
        check("slti_result", result, 32'd1);
        step(1'b1, 3'b010, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'h0);
        check("sltu_result", result, 32'd0);
        step(1'b1, 3'b010, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0);
        check("and_result", result, 32'h00F0_00F0);
        step(1'b1, 3'b010, 3'b110, 1'b0, 32'hF000_0000, 32'h0000_000F, 32'h0, 32'h0);
        check("or_result", result, 32'hF000_000F);
        step(1'b1, 3'b111, 3'b111, 1'b1, 32'd2, 32'd3, 32'h0, 32'h0);
        check("aluop_111_add", result, 32'd5);

`ifdef ALU_OVERFLOW_EN
        step(1'b1, 3'b000, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("add_ovf_result", result, 32'h8000_0000);
        check("add_ovf_flag", {31'b0, overflow}, 32'h1);
        step(1'b1, 3'b010, 3'b000, 1'b1, 32'd0, 32'd1, 32'h0, 32'h0);
        check("sub_noovf_result", result, 32'hFFFF_FFFF);
        check("sub_noovf_flag", {31'b0, overflow}, 32'h0);
        step(1'b1, 3'b010, 3'b000, 1'b1, 32'h8000_0000, 32'd1, 32'h0, 32'h0);
        check("sub_ovf_flag", {31'b0, overflow}, 32'h1);
        step(1'b1, 3'b010, 3'b110, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0);
        check("or_noovf_flag", {31'b0, overflow}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
